// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : reset_sequencer
//  Description : Reset generator for downstream active-low async-reset
//                domains. Asserts every domain reset immediately on the
//                board reset, stretches it for a minimum hold time, then
//                releases the domains one by one, synchronously to clk, in
//                a fixed staggered order. Software and watchdog requests
//                restart the hold/release sequence, and the source of the
//                most recent reset is reported on `cause`.
//  Revision    : 1.0  - initial release
// ============================================================================
module reset_sequencer #(
    parameter int SYNC_STAGES = 2,   // deassertion / watchdog synchronizer depth (>= 2)
    parameter int NUM_OUT     = 3,   // number of staged domain resets (1..8)
    parameter int HOLD_CYCLES = 16,  // minimum hold time in cycles (>= 1)
    parameter int STAGE_GAP   = 8,   // cycles between consecutive domain releases (>= 1)
    parameter int CNT_W       = 8    // counter width, holds max(HOLD_CYCLES, STAGE_GAP)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sw_req,
    input  logic               wdt_req,
    output logic [NUM_OUT-1:0] rstn_out,
    output logic               rst_done,
    output logic               busy,
    output logic [1:0]         cause
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_CAUSE_POR = 2'b01;
    localparam logic [1:0] c_CAUSE_SW  = 2'b10;
    localparam logic [1:0] c_CAUSE_WDT = 2'b11;

    localparam logic [CNT_W-1:0]   c_CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0]   c_CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   c_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [NUM_OUT-1:0] c_RSTN_ONE  = NUM_OUT'(1);

    // Sequencer states, explicitly encoded
    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_rst_sync;
    logic [SYNC_STAGES-1:0] r_wdt_sync;
    logic                   r_wdt_prev;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [NUM_OUT-1:0]     r_rstn;
    logic                   r_done;
    logic                   r_busy;
    logic [1:0]             r_cause;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                   w_rst_s;
    logic                   w_wdt_lvl;
    logic                   w_wdt_edge;
    logic                   w_req;
    logic [1:0]             w_req_cause;
    logic [NUM_OUT-1:0]     w_rstn_shift;
    logic                   w_rstn_full;

    // Internal reset, released SYNC_STAGES edges after rst falls
    assign w_rst_s     = r_rst_sync[SYNC_STAGES-1];

    // Watchdog request is the rising edge of the synchronized level
    assign w_wdt_lvl   = r_wdt_sync[SYNC_STAGES-1];
    assign w_wdt_edge  = w_wdt_lvl & ~r_wdt_prev;

    // Any request; the watchdog wins when both arrive in the same cycle
    assign w_req       = sw_req | w_wdt_edge;
    assign w_req_cause = w_wdt_edge ? c_CAUSE_WDT : c_CAUSE_SW;

    // Next thermometer value: release one more domain, lowest bit first
    assign w_rstn_shift = (r_rstn << 1) | c_RSTN_ONE;
    assign w_rstn_full  = &w_rstn_shift;

    // ------------------------------------------------------------------------
    // Reset deassertion synchronizer: set asynchronously, shifts zeros in
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rst_sync <= '1;
        end else begin
            r_rst_sync <= {r_rst_sync[SYNC_STAGES-2:0], 1'b0};
        end
    end

    // ------------------------------------------------------------------------
    // Watchdog level synchronizer plus previous-value flop for edge detection
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdt_sync <= '0;
            r_wdt_prev <= 1'b0;
        end else begin
            r_wdt_sync <= {r_wdt_sync[SYNC_STAGES-2:0], wdt_req};
            r_wdt_prev <= w_wdt_lvl;
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer FSM with registered domain resets, done, busy and cause
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RESET;
            r_cnt   <= c_CNT_ZERO;
            r_rstn  <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_cause <= c_CAUSE_POR;
        end else begin
            case (r_state)
                // Wait for the synchronized internal reset to drop.
                // rst_s fell on the previous edge, which already counts as
                // the first hold cycle, so the counter resumes from one.
                ST_RESET: begin
                    if (!w_rst_s) begin
                        if (HOLD_CYCLES == 1) begin
                            r_rstn  <= w_rstn_shift;
                            r_busy  <= ~w_rstn_full;
                            r_cnt   <= c_CNT_ZERO;
                            r_state <= w_rstn_full ? ST_RUN : ST_RELEASE;
                        end else begin
                            r_cnt   <= c_CNT_ONE;
                            r_state <= ST_HOLD;
                        end
                    end
                end

                // Stretch reset; a new request restarts the hold window
                ST_HOLD: begin
                    if (w_req) begin
                        r_cnt   <= c_CNT_ZERO;
                        r_cause <= w_req_cause;
                    end else if (r_cnt >= c_HOLD_LAST) begin
                        r_rstn  <= w_rstn_shift;
                        r_busy  <= ~w_rstn_full;
                        r_cnt   <= c_CNT_ZERO;
                        r_state <= w_rstn_full ? ST_RUN : ST_RELEASE;
                    end else begin
                        r_cnt   <= r_cnt + c_CNT_ONE;
                    end
                end

                // Release the remaining domains every STAGE_GAP cycles
                ST_RELEASE: begin
                    if (w_req) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= c_CNT_ZERO;
                        r_rstn  <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_cause <= w_req_cause;
                    end else if (r_cnt >= c_GAP_LAST) begin
                        r_rstn  <= w_rstn_shift;
                        r_busy  <= ~w_rstn_full;
                        r_cnt   <= c_CNT_ZERO;
                        if (w_rstn_full) begin
                            r_state <= ST_RUN;
                        end
                    end else begin
                        r_cnt   <= r_cnt + c_CNT_ONE;
                    end
                end

                // All domains out of reset; done follows one edge later
                ST_RUN: begin
                    if (w_req) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= c_CNT_ZERO;
                        r_rstn  <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_cause <= w_req_cause;
                    end else begin
                        r_done  <= 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_RESET;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs come straight from flops
    // ------------------------------------------------------------------------
    assign rstn_out = r_rstn;
    assign rst_done = r_done;
    assign busy     = r_busy;
    assign cause    = r_cause;

endmodule
`default_nettype wire
